rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 12000: cycles btn_n must be stable before the debounced level changes (1 ms at 12 MHz); legal values >=2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum sys_rst assertion after reset or button release; legal values >=1.
REQ-003 SHALL have parameter GO_DELAY, default 4: cycles from sys_rst deassertion to the go pulse; legal values >=1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset, driven by the power-on reset generator.
REQ-006 SHALL have port btn_n, input, 1 bit: raw, asynchronous, active-low pushbutton (0 = pressed).
REQ-007 SHALL have port sys_rst, output, 1 bit: active-high core reset; asserts asynchronously and deasserts synchronously.
REQ-008 SHALL have port go, output, 1 bit: one-cycle start pulse for the compute core.
REQ-009 SHALL have port btn_press, output, 1 bit: one-cycle pulse on each debounced press.

Function
REQ-010 SHALL pass btn_n through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-011 SHALL keep a debounced level db (reset 1) and a debounce counter of width clog2(DB_CYCLES) (reset 0).
REQ-012 On each edge where the synchronized value equals db, the counter SHALL clear to 0.
REQ-013 On each edge where the synchronized value differs from db and the counter < DB_CYCLES-1, the counter SHALL increment.
REQ-014 On each edge where the synchronized value differs from db and the counter == DB_CYCLES-1, db SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-015 Any glitch shorter than DB_CYCLES synchronized cycles SHALL leave db unchanged; the counter never wraps.
REQ-016 btn_press SHALL be a registered output that is 1 for exactly the cycle after the edge where db goes 1->0, and 0 otherwise; a release produces no pulse.
REQ-017 SHALL implement the FSM {HOLD, WAIT, RUN} with a shared phase counter wide enough for max(HOLD_CYCLES, GO_DELAY)-1.
REQ-018 HOLD: if db==0 (button held), the counter SHALL be forced to 0.
REQ-019 HOLD: otherwise, at counter == HOLD_CYCLES-1 the FSM SHALL go to WAIT with the counter cleared; below that value the counter SHALL increment.
REQ-020 WAIT: at counter == GO_DELAY-1 the FSM SHALL go to RUN; otherwise the counter SHALL increment.
REQ-021 WAIT and RUN: a btn_press pulse SHALL move the FSM to HOLD with the counter cleared; in WAIT the press takes priority over the go transition.
REQ-022 RUN SHALL be held indefinitely until a btn_press pulse.
REQ-023 sys_rst SHALL be registered as (next state == HOLD), so it falls at the edge HOLD exits and rises at the edge HOLD is entered.
REQ-024 go SHALL be registered, 1 only for the cycle after the WAIT->RUN edge; go and sys_rst SHALL never both be 1.
REQ-025 Latency, button released and edge 1 = first edge after rst falls: sys_rst SHALL fall at edge HOLD_CYCLES, and go SHALL be high from edge HOLD_CYCLES+GO_DELAY for one cycle.
REQ-026 Latency, btn_n going low before edge k and staying low: btn_press SHALL pulse after edge k+1+DB_CYCLES, and sys_rst SHALL rise at edge k+2+DB_CYCLES.

Reset
REQ-027 rst=1 SHALL asynchronously force: state HOLD; both counters 0; synchronizer flops and db 1; sys_rst 1; go 0; btn_press 0.
REQ-028 rst asserted mid-operation (any state) SHALL take effect without waiting for a clock; the sequence restarts from REQ-025 after rst falls.
REQ-029 rst SHALL be the only asynchronous input affecting flops; btn_n is used only through the synchronizer.

Verification (bench params DB_CYCLES=4, HOLD_CYCLES=3, GO_DELAY=2)
REQ-030 Power-up: rst high 5 cycles, then low, btn_n=1 -> sys_rst 1 through edge 2, 0 from edge 3; go=1 only between edges 5 and 6; go 0 for 50 further cycles.
REQ-031 Glitch: in RUN, btn_n low for 3 cycles then high -> no btn_press, sys_rst stays 0.
REQ-032 Press-hold: in RUN, btn_n low from before edge k for 20 cycles -> btn_press pulse after edge k+5; sys_rst rises at edge k+6 and stays 1 while held.
REQ-033 Press-hold, continued: sys_rst falls 3 cycles after db returns to 1; go pulses 2 cycles later.
REQ-034 Press in WAIT: btn_press arriving on the go-transition edge -> FSM to HOLD, go stays 0, sys_rst 1.
REQ-035 Async reset mid-RUN: rst pulsed between clock edges -> sys_rst 1 immediately (before the next edge), go 0, and the REQ-030 sequence replays.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: debounces the reset pushbutton and sequences the core reset and start pulse.
// Power-up or a debounced press holds sys_rst, then a delayed one-cycle go follows its release.
module rst_seq #(
    parameter int DB_CYCLES   = 12000,
    parameter int HOLD_CYCLES = 16,
    parameter int GO_DELAY    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic sys_rst,
    output logic go,
    output logic btn_press
);
    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int PMAX = HOLD_CYCLES > GO_DELAY ? HOLD_CYCLES : GO_DELAY;
    localparam int PW   = PMAX > 1 ? $clog2(PMAX) : 1;

    typedef enum logic [1:0] {HOLD, WAIT, RUN} state_t;

    logic [1:0]     r_sync;
    logic           r_db;
    logic [DBW-1:0] r_db_cnt;
    logic           r_press;
    state_t         r_state;
    logic [PW-1:0]  r_cnt;
    logic           r_sys_rst;
    logic           r_go;
    logic           w_db_flip;
    state_t         w_state_nx;
    logic [PW-1:0]  w_cnt_nx;

    // db only changes once the synchronized level has disagreed for DB_CYCLES edges
    assign w_db_flip = (r_sync[1] != r_db) && (r_db_cnt == DBW'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_db     <= 1'b1;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], btn_n};
            r_db     <= w_db_flip ? r_sync[1] : r_db;
            r_db_cnt <= (r_sync[1] == r_db || w_db_flip) ? '0 : r_db_cnt + 1'b1;
            r_press  <= w_db_flip & r_db;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            HOLD: begin
                if (!r_db) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == PW'(HOLD_CYCLES - 1)) begin
                    w_state_nx = WAIT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (r_press) begin
                    w_state_nx = HOLD;
                    w_cnt_nx   = '0;
                end else if (r_cnt == PW'(GO_DELAY - 1)) begin
                    w_state_nx = RUN;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (r_press) begin
                    w_state_nx = HOLD;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = HOLD;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_sys_rst <= 1'b1;
            r_go      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_sys_rst <= (w_state_nx == HOLD);
            r_go      <= (r_state == WAIT) && (w_state_nx == RUN);
        end
    end

    assign sys_rst   = r_sys_rst;
    assign go        = r_go;
    assign btn_press = r_press;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed bench for rst_seq with DB_CYCLES=4, HOLD_CYCLES=3, GO_DELAY=2.
module tb_rst_seq;
    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic sys_rst, go, btn_press;
    int   n_chk = 0;
    int   n_fail = 0;

    rst_seq #(.DB_CYCLES(4), .HOLD_CYCLES(3), .GO_DELAY(2)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .sys_rst(sys_rst), .go(go), .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called right after rst is released (between edges); edge 1 is the next rising edge.
    task automatic pu_seq();
        step(1); chk("pu_e1_sys_rst", sys_rst, 1'b1);
        step(1); chk("pu_e2_sys_rst", sys_rst, 1'b1); chk("pu_e2_go", go, 1'b0);
        step(1); chk("pu_e3_sys_rst", sys_rst, 1'b0); chk("pu_e3_go", go, 1'b0);
        step(1); chk("pu_e4_go", go, 1'b0);
        step(1); chk("pu_e5_go", go, 1'b1); chk("pu_e5_sys_rst", sys_rst, 1'b0);
        step(1); chk("pu_e6_go", go, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("pu_idle_go", go, 1'b0);
            chk("pu_idle_sys_rst", sys_rst, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        btn_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_sys_rst", sys_rst, 1'b1);
        chk("rst_go", go, 1'b0);
        chk("rst_btn_press", btn_press, 1'b0);
        step(5);
        chk("rst_hold_sys_rst", sys_rst, 1'b1);
        rst = 1'b0;
        pu_seq();

        // 3-cycle glitch in RUN must be filtered
        btn_n = 1'b0;
        step(3);
        btn_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("glitch_btn_press", btn_press, 1'b0);
            chk("glitch_sys_rst", sys_rst, 1'b0);
        end

        // press and hold 20 cycles
        btn_n = 1'b0;
        step(5); chk("ph_k4_press", btn_press, 1'b0);
        step(1); chk("ph_k5_press", btn_press, 1'b1); chk("ph_k5_sys_rst", sys_rst, 1'b0);
        step(1); chk("ph_k6_press", btn_press, 1'b0); chk("ph_k6_sys_rst", sys_rst, 1'b1);
        for (int i = 0; i < 13; i++) begin
            step(1);
            chk("ph_held_sys_rst", sys_rst, 1'b1);
            chk("ph_held_go", go, 1'b0);
        end
        btn_n = 1'b1;
        step(8); chk("rel_j7_sys_rst", sys_rst, 1'b1); chk("rel_j7_press", btn_press, 1'b0);
        step(1); chk("rel_j8_sys_rst", sys_rst, 1'b0);
        step(1); chk("rel_j9_go", go, 1'b0);
        step(1); chk("rel_j10_go", go, 1'b1);
        step(1); chk("rel_j11_go", go, 1'b0);

        // press landing on the WAIT->RUN edge
        btn_n = 1'b0;
        step(6); chk("pw_press", btn_press, 1'b1);
        step(1); chk("pw_sys_rst", sys_rst, 1'b1);
        step(10);
        btn_n = 1'b1;
        step(4);
        btn_n = 1'b0;
        step(5); chk("pw_j8_sys_rst", sys_rst, 1'b0); chk("pw_j8_go", go, 1'b0);
        step(1); chk("pw_j9_press", btn_press, 1'b1); chk("pw_j9_sys_rst", sys_rst, 1'b0);
        chk("pw_j9_go", go, 1'b0);
        step(1); chk("pw_j10_sys_rst", sys_rst, 1'b1); chk("pw_j10_go", go, 1'b0);
        step(1); chk("pw_j11_sys_rst", sys_rst, 1'b1); chk("pw_j11_go", go, 1'b0);
        step(3);
        btn_n = 1'b1;
        step(10); chk("pw_rel_sys_rst", sys_rst, 1'b0); chk("pw_rel_go0", go, 1'b0);
        step(1); chk("pw_rel_go", go, 1'b1);

        // async reset between edges while go is high
        #2 rst = 1'b1;
        #1;
        chk("async_sys_rst", sys_rst, 1'b1);
        chk("async_go", go, 1'b0);
        chk("async_btn_press", btn_press, 1'b0);
        step(3);
        chk("async_hold_sys_rst", sys_rst, 1'b1);
        rst = 1'b0;
        pu_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
